// File: rtl/async_fifo_wr_arbiter_pkg.sv
// Shared types and defaults for the async FIFO write-port arbiter.
package async_fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  localparam int unsigned CNT_W       = 16;
  localparam int unsigned DEF_NREQ    = 4;
  localparam int unsigned DEF_DSIZE   = 8;
  localparam int unsigned DEF_TIMEOUT = 64;

endpackage

// File: rtl/async_fifo_rr_pick.sv
// Rotate-priority picker: first set request at or above rr_ptr, modulo NREQ.
module async_fifo_rr_pick
  import async_fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic            valid,
  output logic [IW-1:0]   index
);

  int unsigned k;

  // Scan offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    valid = |req;
    index = '0;
    k     = 0;
    for (int unsigned off = NREQ; off > 0; off--) begin
      k = (32'(rr_ptr) + off - 1) % NREQ;
      if (req[k]) index = IW'(k);
    end
  end

endmodule

// File: rtl/async_fifo_wr_arbiter.sv
// Packet-aware round-robin arbiter for the write port of an async FIFO.
// Optional stall timeout: define ASYNC_FIFO_WR_ARBITER_TIMEOUT_EN.
module async_fifo_wr_arbiter
  import async_fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ    = DEF_NREQ,
  parameter int unsigned DSIZE   = DEF_DSIZE,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                    wclk,
  input  logic                    wrst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DSIZE-1:0]   req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         req_ready,
  output logic [DSIZE:0]          fifo_wdata,
  output logic                    fifo_winc,
  input  logic                    fifo_wfull,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic [CNT_W-1:0]        pkt_cnt,
  output logic                    timeout_err
);

  localparam int unsigned IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("async_fifo_wr_arbiter: parameter out of range");
  end

  arb_state_t    state, state_nxt;
  logic [IW-1:0] rr_ptr, ptr_nxt, grant_nxt, g_inc, pick_idx;
  logic          pick_vld, done, force_rel;

  async_fifo_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .valid  (pick_vld),
    .index  (pick_idx)
  );

  // Handshake and write datapath, combinational from the current grant.
  always_comb begin
    req_ready  = '0;
    fifo_winc  = 1'b0;
    fifo_wdata = {req_last[grant_id], req_data[32'(grant_id) * DSIZE +: DSIZE]};
    if (state == XFER) begin
      req_ready[grant_id] = ~fifo_wfull;
      fifo_winc           = req_valid[grant_id] & ~fifo_wfull;
    end
  end

  assign busy  = (state == XFER);
  assign done  = fifo_winc & req_last[grant_id];
  assign g_inc = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

`ifdef ASYNC_FIFO_WR_ARBITER_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] stall_cnt;

  // Fires on the TIMEOUT-th consecutive XFER cycle without an accepted beat.
  assign force_rel = (state == XFER) && !fifo_winc && (stall_cnt == TO_W'(TIMEOUT - 1));

  // Stall counter clears in IDLE (so it starts at 0 on grant) and on every accepted beat.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= force_rel;
      if (state != XFER || fifo_winc || force_rel) stall_cnt <= '0;
      else                                         stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  assign force_rel   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next-state: grant from IDLE, release after the last beat or on timeout.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    ptr_nxt   = rr_ptr;
    unique case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt = XFER;
          grant_nxt = pick_idx;
        end
      end
      XFER: begin
        if (done || force_rel) begin
          state_nxt = IDLE;
          ptr_nxt   = g_inc;
        end
      end
    endcase
  end

  // Arbitration state and packet counter.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      pkt_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= ptr_nxt;
      grant_id <= grant_nxt;
      if (done) pkt_cnt <= pkt_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Self-checking bench for async_fifo_wr_arbiter (NREQ=4, DSIZE=8, TIMEOUT=8).
module tb_async_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int DSIZE = 8;
  localparam int TOUT  = 8;
`ifdef ASYNC_FIFO_WR_ARBITER_TIMEOUT_EN
  localparam int FULL_STALL = 6;
`else
  localparam int FULL_STALL = 10;
`endif

  logic                  wclk = 1'b0;
  logic                  wrst_n = 1'b0;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic [DSIZE:0]        fifo_wdata;
  logic                  fifo_winc;
  logic                  fifo_wfull;
  logic [1:0]            grant_id;
  logic                  busy;
  logic [15:0]           pkt_cnt;
  logic                  timeout_err;

  int n_checks = 0;
  int n_pass   = 0;

  // stream control (written by tasks)
  int tot  [NREQ];
  int plen [NREQ];
  bit hold [NREQ];
  bit rand_valid, rand_full, full_force;
  // stream progress (written by the monitor)
  int acc  [NREQ];
  int bidx [NREQ];

  async_fifo_wr_arbiter #(
    .NREQ    (NREQ),
    .DSIZE   (DSIZE),
    .TIMEOUT (TOUT)
  ) dut (
    .wclk        (wclk),
    .wrst_n      (wrst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .fifo_wdata  (fifo_wdata),
    .fifo_winc   (fifo_winc),
    .fifo_wfull  (fifo_wfull),
    .grant_id    (grant_id),
    .busy        (busy),
    .pkt_cnt     (pkt_cnt),
    .timeout_err (timeout_err)
  );

  always #5 wclk = ~wclk;

  function automatic logic [7:0] beat_data(int i, int k);
    return 8'((i << 6) | (k & 63));
  endfunction

  // Requester driver: inputs change 1 unit after the rising edge.
  initial begin
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;
    fifo_wfull = 1'b0;
    forever begin
      @(posedge wclk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i] = (acc[i] < tot[i]) && !hold[i] &&
                       (!rand_valid || $urandom_range(0, 99) < 70);
        req_data[i*DSIZE +: DSIZE] = beat_data(i, acc[i]);
        req_last[i] = (bidx[i] == plen[i] - 1);
      end
      fifo_wfull = full_force || (rand_full && $urandom_range(0, 99) < 20);
    end
  end

  // Handshake bookkeeping: advance a requester's stream on valid&ready.
  always @(negedge wclk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (!wrst_n) begin
        acc[i]  = 0;
        bidx[i] = 0;
      end else if (req_valid[i] && req_ready[i]) begin
        acc[i]  = acc[i] + 1;
        bidx[i] = (bidx[i] >= plen[i] - 1) ? 0 : bidx[i] + 1;
      end
    end
  end

  // Reference model: per-cycle expectations derived from the arbitration rules.
  int m_owner = -1, m_ptr = 0, m_cnt = 0, m_stall = 0, m_gid = 0;
  bit m_terr_nxt = 1'b0;
  bit exp_busy, exp_winc, exp_terr;
  logic [1:0]      exp_gid;
  logic [NREQ-1:0] exp_ready;
  logic [DSIZE:0]  exp_wdata;
  logic [15:0]     exp_cnt;

  always @(negedge wclk) begin
    if (!wrst_n) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_stall = 0; m_gid = 0; m_terr_nxt = 1'b0;
      exp_busy = 1'b0; exp_winc = 1'b0; exp_terr = 1'b0;
      exp_gid = '0; exp_ready = '0; exp_wdata = '0; exp_cnt = '0;
    end else begin
      exp_terr   = m_terr_nxt;
      m_terr_nxt = 1'b0;
      exp_cnt    = 16'(m_cnt);
      exp_busy   = (m_owner >= 0);
      exp_gid    = 2'(m_gid);
      exp_ready  = '0;
      exp_winc   = 1'b0;
      exp_wdata  = '0;
      if (m_owner < 0) begin
        if (req_valid != '0) begin
          for (int d = NREQ - 1; d >= 0; d--)
            if (req_valid[(m_ptr + d) % NREQ]) m_owner = (m_ptr + d) % NREQ;
          m_gid   = m_owner;
          m_stall = 0;
        end
      end else begin
        exp_wdata = {req_last[m_owner], req_data[m_owner*DSIZE +: DSIZE]};
        exp_ready[m_owner] = !fifo_wfull;
        exp_winc = req_valid[m_owner] && !fifo_wfull;
        if (exp_winc) begin
          m_stall = 0;
          if (req_last[m_owner]) begin
            m_cnt   = m_cnt + 1;
            m_ptr   = (m_owner + 1) % NREQ;
            m_owner = -1;
          end
        end else begin
`ifdef ASYNC_FIFO_WR_ARBITER_TIMEOUT_EN
          m_stall = m_stall + 1;
          if (m_stall == TOUT) begin
            m_ptr      = (m_owner + 1) % NREQ;
            m_owner    = -1;
            m_terr_nxt = 1'b1;
          end
`endif
        end
      end
    end
  end

  task automatic clear_streams();
    tot = '{default: 0}; plen = '{default: 1}; hold = '{default: 0};
    rand_valid = 1'b0; rand_full = 1'b0; full_force = 1'b0;
  endtask

  task automatic do_reset();
    clear_streams();
    @(posedge wclk); #2; wrst_n = 1'b0;
    repeat (2) @(posedge wclk);
    #2; wrst_n = 1'b1;
  endtask

  task automatic sample();
    @(negedge wclk); #1;
  endtask

  task automatic test_reset();
    int t;
    clear_streams();
    plen = '{default: 3}; tot = '{default: 3};
    @(posedge wclk); #2; wrst_n = 1'b0;
    repeat (3) begin
      sample();
      n_checks++; if ({busy, fifo_winc, req_ready, timeout_err} !== 7'b0)
        $display("FAIL reset_ctl: got %b want 0000000", {busy, fifo_winc, req_ready, timeout_err}); else n_pass++;
      n_checks++; if ({grant_id, pkt_cnt} !== 18'b0)
        $display("FAIL reset_cnt: got gid=%0d pkt=%0d want 0/0", grant_id, pkt_cnt); else n_pass++;
    end
    @(posedge wclk); #2; wrst_n = 1'b1;
    sample();
    n_checks++; if (busy !== 1'b0) $display("FAIL arb_cycle: busy=%b want 0", busy); else n_pass++;
    sample();
    t = {30'b0, grant_id};
    n_checks++; if (busy !== 1'b1 || t != 0)
      $display("FAIL first_grant: busy=%b gid=%0d want 1/0", busy, t); else n_pass++;
  endtask

  task automatic test_round_robin();
    int t, g, k;
    int order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    plen = '{default: 3}; tot = '{6, 3, 3, 3};
    t = 0;
    do begin sample(); t++; end while (fifo_winc !== 1'b1 && t < 20);
    n_checks++; if (fifo_winc !== 1'b1) $display("FAIL rr_start: no write in %0d cycles", t); else n_pass++;
    for (int p = 0; p < 19; p++) begin
      g = order[p/4];
      k = (p / 4 == 4) ? 3 + (p % 4) : (p % 4);
      n_checks++; if (fifo_winc !== (p % 4 != 3))
        $display("FAIL rr_winc[%0d]: got %b want %b", p, fifo_winc, (p % 4 != 3)); else n_pass++;
      if (p % 4 != 3) begin
        n_checks++; if (grant_id !== 2'(g) || fifo_wdata !== {(p % 4 == 2), beat_data(g, k)})
          $display("FAIL rr_beat[%0d]: gid=%0d wdata=%h want %0d/%h", p, grant_id, fifo_wdata, g,
                   {(p % 4 == 2), beat_data(g, k)}); else n_pass++;
      end
      sample();
    end
    sample();
    n_checks++; if (pkt_cnt !== 16'd5 || busy !== 1'b0)
      $display("FAIL rr_done: pkt=%0d busy=%b want 5/0", pkt_cnt, busy); else n_pass++;
  endtask

  task automatic test_backpressure();
    int k, fcount;
    do_reset();
    plen[2] = 6; tot[2] = 6;
    k = 0; fcount = -1;
    for (int c = 0; c < 60 && k < 6; c++) begin
      sample();
      if (fcount > 0) begin
        n_checks++; if (fifo_winc !== 1'b0 || req_ready !== 4'b0)
          $display("FAIL full_gate: winc=%b ready=%b want 0/0000", fifo_winc, req_ready); else n_pass++;
        fcount--;
        if (fcount == 0) full_force = 1'b0;
      end else if (fifo_winc === 1'b1) begin
        n_checks++; if (fifo_wdata !== {(k == 5), beat_data(2, k)})
          $display("FAIL full_beat[%0d]: got %h want %h", k, fifo_wdata, {(k == 5), beat_data(2, k)}); else n_pass++;
        k++;
        if (k == 2 && fcount < 0) begin full_force = 1'b1; fcount = FULL_STALL; end
      end
    end
    n_checks++; if (k != 6) $display("FAIL full_count: got %0d beats want 6", k); else n_pass++;
    repeat (4) begin
      sample();
      n_checks++; if (fifo_winc !== 1'b0) $display("FAIL full_dup: winc=%b want 0", fifo_winc); else n_pass++;
    end
    n_checks++; if (pkt_cnt !== 16'd1) $display("FAIL full_pkt: got %0d want 1", pkt_cnt); else n_pass++;
  endtask

  task automatic test_drop_valid();
    int k, t;
    int ids[$];
    do_reset();
    plen[1] = 4; tot[1] = 4;
    k = 0; t = 0;
    while (k < 2 && t < 30) begin sample(); t++; if (fifo_winc === 1'b1) k++; end
    n_checks++; if (k != 2) $display("FAIL drop_start: got %0d beats want 2", k); else n_pass++;
    hold[1] = 1'b1; plen[3] = 2; tot[3] = 2;
    for (int s = 0; s < 5; s++) begin
      sample();
      n_checks++; if ({busy, grant_id, fifo_winc, req_ready[3]} !== 5'b10100)
        $display("FAIL drop_hold[%0d]: busy=%b gid=%0d winc=%b rdy3=%b want 1/1/0/0", s, busy, grant_id,
                 fifo_winc, req_ready[3]); else n_pass++;
    end
    hold[1] = 1'b0;
    t = 0;
    while (ids.size() < 4 && t < 30) begin
      sample(); t++;
      if (fifo_winc === 1'b1) ids.push_back({30'b0, grant_id});
    end
    n_checks++; if (ids.size() != 4) $display("FAIL drop_count: got %0d writes want 4", ids.size());
    else if (ids[0] != 1 || ids[1] != 1 || ids[2] != 3 || ids[3] != 3)
      $display("FAIL drop_order: got %0d,%0d,%0d,%0d want 1,1,3,3", ids[0], ids[1], ids[2], ids[3]);
    else n_pass++;
  endtask

  task automatic test_single_beat();
    int t;
    do_reset();
    plen[0] = 1; tot[0] = 6;
    t = 0;
    do begin sample(); t++; end while (fifo_winc !== 1'b1 && t < 20);
    for (int p = 0; p < 11; p++) begin
      n_checks++; if (fifo_winc !== (p % 2 == 0) || grant_id !== 2'd0)
        $display("FAIL single[%0d]: winc=%b gid=%0d want %b/0", p, fifo_winc, grant_id, (p % 2 == 0)); else n_pass++;
      sample();
    end
    n_checks++; if (pkt_cnt !== 16'd6) $display("FAIL single_pkt: got %0d want 6", pkt_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid_xfer();
    int t;
    do_reset();
    plen = '{default: 3}; tot[0] = 3;
    t = 0;
    do begin sample(); t++; end while (pkt_cnt !== 16'd1 && t < 30);
    plen[2] = 5; tot[2] = 5;
    t = 0;
    do begin sample(); t++; end while (!(fifo_winc === 1'b1 && grant_id === 2'd2) && t < 30);
    n_checks++; if (grant_id !== 2'd2) $display("FAIL mid_grant: gid=%0d want 2", grant_id); else n_pass++;
    @(posedge wclk); #3;
    wrst_n = 1'b0;
    tot = '{default: 0};
    #1;
    n_checks++; if ({busy, fifo_winc, req_ready, timeout_err, grant_id, pkt_cnt} !== 25'b0)
      $display("FAIL mid_reset: busy=%b winc=%b rdy=%b terr=%b gid=%0d pkt=%0d want all 0", busy, fifo_winc,
               req_ready, timeout_err, grant_id, pkt_cnt); else n_pass++;
    repeat (2) @(posedge wclk);
    #2; wrst_n = 1'b1;
    tot[1] = 3; tot[3] = 3;
    t = 0;
    do begin sample(); t++; end while (fifo_winc !== 1'b1 && t < 20);
    n_checks++; if (fifo_winc !== 1'b1 || grant_id !== 2'd1)
      $display("FAIL mid_restart: winc=%b gid=%0d want 1/1", fifo_winc, grant_id); else n_pass++;
  endtask

  task automatic test_timeout();
    int t;
    do_reset();
    plen[1] = 4; tot[1] = 4;
    t = 0;
    do begin sample(); t++; end while (fifo_winc !== 1'b1 && t < 20);
    hold[1] = 1'b1;
`ifdef ASYNC_FIFO_WR_ARBITER_TIMEOUT_EN
    for (int s = 1; s <= TOUT; s++) begin
      sample();
      n_checks++; if (busy !== 1'b1 || timeout_err !== 1'b0)
        $display("FAIL to_stall[%0d]: busy=%b terr=%b want 1/0", s, busy, timeout_err); else n_pass++;
    end
    sample();
    n_checks++; if (busy !== 1'b0 || timeout_err !== 1'b1 || pkt_cnt !== 16'd0)
      $display("FAIL to_fire: busy=%b terr=%b pkt=%0d want 0/1/0", busy, timeout_err, pkt_cnt); else n_pass++;
    hold[1] = 1'b0; plen[0] = 2; tot[0] = 2;
    sample();
    n_checks++; if (timeout_err !== 1'b0) $display("FAIL to_pulse: terr=%b want 0", timeout_err); else n_pass++;
    t = 0;
    do begin sample(); t++; end while (fifo_winc !== 1'b1 && t < 20);
    n_checks++; if (fifo_winc !== 1'b1 || grant_id !== 2'd0)
      $display("FAIL to_rr: winc=%b gid=%0d want 1/0", fifo_winc, grant_id); else n_pass++;
`else
    for (int s = 1; s <= 20; s++) begin
      sample();
      n_checks++; if (busy !== 1'b1 || grant_id !== 2'd1 || timeout_err !== 1'b0)
        $display("FAIL hold_grant[%0d]: busy=%b gid=%0d terr=%b want 1/1/0", s, busy, grant_id, timeout_err);
      else n_pass++;
    end
    hold[1] = 1'b0;
    t = 0;
    do begin sample(); t++; end while (pkt_cnt !== 16'd1 && t < 20);
    n_checks++; if (pkt_cnt !== 16'd1) $display("FAIL hold_done: pkt=%0d want 1", pkt_cnt); else n_pass++;
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      plen[i] = $urandom_range(1, 4);
      tot[i]  = plen[i] * 8;
    end
    rand_valid = 1'b1; rand_full = 1'b1;
    repeat (400) begin
      sample();
      n_checks++; if ({busy, grant_id, fifo_winc, req_ready, timeout_err} !== {exp_busy, exp_gid, exp_winc, exp_ready, exp_terr})
        $display("FAIL rnd_ctl: busy=%b gid=%0d winc=%b rdy=%b terr=%b want %b/%0d/%b/%b/%b", busy, grant_id,
                 fifo_winc, req_ready, timeout_err, exp_busy, exp_gid, exp_winc, exp_ready, exp_terr);
      else n_pass++;
      n_checks++; if (pkt_cnt !== exp_cnt) $display("FAIL rnd_pkt: got %0d want %0d", pkt_cnt, exp_cnt); else n_pass++;
      if (exp_busy) begin
        n_checks++; if (fifo_wdata !== exp_wdata)
          $display("FAIL rnd_wdata: got %h want %h", fifo_wdata, exp_wdata); else n_pass++;
      end
    end
  endtask

  initial begin
    clear_streams();
    test_reset();
    test_round_robin();
    test_backpressure();
    test_drop_valid();
    test_single_beat();
    test_reset_mid_xfer();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/async_fifo_wr_arbiter.md
# async_fifo_wr_arbiter

Packet-aware round-robin arbiter that shares the write port of one asynchronous FIFO among NREQ requesters in the write clock domain. It grants one requester at a time and holds the grant until that requester's last beat. It drives the FIFO write increment, gated by the FIFO full flag, and tags each word with an end-of-packet bit. It sits directly in front of the FIFO write-pointer/full logic and the FIFO memory write port.

## Interface
Parameters:
- NREQ, 4: number of requesters, 2..8.
- DSIZE, 8: payload width.
- TIMEOUT, 64: stall cycles before forced release. Used only with the macro.

Ports:
- wclk  in  1  write-domain clock.
- wrst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester beat valid.
- req_data  in  NREQ*DSIZE  payloads, requester i at [i*DSIZE +: DSIZE].
- req_last  in  NREQ  beat is the final beat of a packet.
- req_ready  out  NREQ  beat accepted this cycle when valid&ready.
- fifo_wdata  out  DSIZE+1  {last, data} of the granted requester.
- fifo_winc  out  1  write strobe to the FIFO.
- fifo_wfull  in  1  registered full flag from the FIFO.
- grant_id  out  $clog2(NREQ)  current or most recent grantee.
- busy  out  1  high in XFER.
- pkt_cnt  out  16  packets completed, wraps.
- timeout_err  out  1  one-cycle pulse on forced release (tied 0 without the macro).

## Operation
- FSM states: IDLE, XFER.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from rr_ptr upward, modulo NREQ.
  - Register that requester in grant_id and move to XFER.
  - No beat is accepted in IDLE.
- XFER, with g = grant_id:
  - req_ready[g] = ~fifo_wfull. All other req_ready are 0.
  - fifo_winc = req_valid[g] & ~fifo_wfull.
  - fifo_wdata = {req_last[g], req_data[g]}. It carries the grantee's data even when fifo_winc=0.
- On an accepted beat with req_last[g]=1:
  - Go to IDLE.
  - rr_ptr <= (g+1) mod NREQ.
  - pkt_cnt increments.
- Grant is never revoked mid-packet, except by timeout when the macro is defined.
- Requests that arrive mid-packet wait. Deasserting req_valid without an accepted beat is legal; no beat is lost.
- fifo_winc is never asserted while fifo_wfull=1. This holds even though the FIFO also gates internally.
- Single requester: every packet costs one IDLE cycle.
- Reset values (async, on wrst_n low):
  - State IDLE, rr_ptr 0, grant_id 0, pkt_cnt 0.
  - busy 0, fifo_winc 0, req_ready all 0, timeout_err 0.
- Reset mid-packet aborts the packet. The FIFO may hold a partial packet, which is the reader's concern.

## Timing
- Arbitration latency: a request seen in IDLE at edge N gives grant at edge N+1. The first beat can be accepted in the cycle after edge N+1.
- Throughput: one beat per cycle in XFER while not full.
- Packet-to-packet gap: exactly one cycle.
- fifo_winc, fifo_wdata and req_ready are combinational from state, req_* and fifo_wfull. There are no registered data stages.
- fifo_wfull updates one cycle after the write that fills the FIFO. Backpressure is therefore exact, with no overrun.
- A single-beat packet (last on the first beat) returns to IDLE the cycle after acceptance.

## Configuration
- ASYNC_FIFO_WR_ARBITER_TIMEOUT_EN defined:
  - A counter resets on each accepted beat and on grant.
  - It increments each XFER cycle with no accepted beat, whether the grantee is idle or the FIFO is full.
  - On reaching TIMEOUT: force IDLE, advance rr_ptr past g, pulse timeout_err for 1 cycle, and do not increment pkt_cnt.
- Undefined: no counter exists, timeout_err is tied 0, and the grant holds indefinitely.

## Structure
- Package async_fifo_arb_pkg:
  - state typedef (IDLE, XFER).
  - CNT_W = 16.
  - Default NREQ/DSIZE/TIMEOUT constants.
- Sub-module async_fifo_rr_pick: combinational rotate-priority picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: valid, index.
  - Instanced once.

## Test plan
- Reset mid-XFER with requester 2 granted: all outputs return to their reset values immediately, and the next grant starts from requester 0.
- All 4 requesters send 3-beat packets continuously: grant order is 0,1,2,3,0. Each packet has 3 contiguous fifo_winc, then a 1-cycle gap. pkt_cnt reaches 5.
- fifo_wfull forced high for 10 cycles mid-packet: fifo_winc and req_ready stay 0. The remaining beats resume in order with none lost or duplicated.
- Requester 1 drops req_valid for 5 cycles mid-packet while requester 3 requests: grant stays 1. Requester 3 is granted only after requester 1's last beat.
- With the macro defined and TIMEOUT=8, the grantee stalls: exactly 8 cycles after the last acceptance the block returns to IDLE, timeout_err pulses once, and pkt_cnt is unchanged.
- Single-beat packets from requester 0 only: grant_id stays 0, and fifo_winc is high every other cycle.
